// File: rtl/sobel_pkg.sv
// sobel_pkg
// Shared defaults and encodings for the Sobel frame path.
//   - Default pixel width, BRAM0 address width and image geometry.
//   - FRAME_SIZE: pixels per frame for the default geometry.
//   - loader_state_t: 2-bit state encoding of the BRAM frame loader.
//   - sat_inc8: saturating 8-bit increment used by error counters.
package sobel_pkg;

   localparam int DEF_DATA_WIDTH   = 8;
   localparam int DEF_ADDR_WIDTH   = 16;
   localparam int DEF_IMAGE_WIDTH  = 5;
   localparam int DEF_IMAGE_HEIGHT = 5;
   localparam int FRAME_SIZE       = DEF_IMAGE_WIDTH * DEF_IMAGE_HEIGHT;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_LOAD      = 2'b01,
      ST_START     = 2'b10,
      ST_WAIT_DONE = 2'b11
   } loader_state_t;

   // Increment an 8-bit counter, holding at 255 instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      logic [7:0] result;
      if (value == 8'hFF) begin
         result = value;
      end else begin
         result = value + 8'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/bram_frame_loader.sv
// bram_frame_loader
// Streams one frame of pixels into an external BRAM (port 0), then pulses
// o_en to hand the stored frame to the Sobel FSM and waits for i_done.
//
// Optional build macro: LOADER_SOF_SYNC_EN
//   defined   : an accepted pixel flagged with i_sof restarts the frame at
//               address 0; a restart with a non-zero counter is counted in
//               o_sof_err_cnt (saturating at 255).
//   undefined : i_sof is ignored and o_sof_err_cnt is tied to 0.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   i_start, i_run    arm one frame load; i_run captured into o_run
//   i_abort           cancel the current frame (highest priority)
//   i_valid, i_sof,
//   i_data, o_ready   pixel stream in, accepted when i_valid && o_ready
//   b0_ce0, b0_we0,
//   b0_addr0, b0_d0   BRAM0 port-0 write interface (same-cycle as accept)
//   o_en, o_num_cnt,
//   o_run, i_done     handshake with the Sobel FSM
//   o_busy            loader not idle
//   o_frame_cnt       completed frames (wraps at 16 bits)
//   o_sof_err_cnt     SOF resynchronisation errors
module bram_frame_loader
   import sobel_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
   parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_start,
   input  logic                  i_run,
   input  logic                  i_abort,
   input  logic                  i_valid,
   input  logic                  i_sof,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_ready,
   output logic                  b0_ce0,
   output logic                  b0_we0,
   output logic [ADDR_WIDTH-1:0] b0_addr0,
   output logic [DATA_WIDTH-1:0] b0_d0,
   output logic                  o_en,
   output logic [ADDR_WIDTH-1:0] o_num_cnt,
   output logic                  o_run,
   input  logic                  i_done,
   output logic                  o_busy,
   output logic [15:0]           o_frame_cnt,
   output logic [7:0]            o_sof_err_cnt
);

   localparam logic [ADDR_WIDTH-1:0] FRAME_LEN = ADDR_WIDTH'(IMAGE_WIDTH * IMAGE_HEIGHT);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);
   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};

   loader_state_t         state_r;
   logic [ADDR_WIDTH-1:0] cnt_r;
   logic                  run_r;
   logic [15:0]           frame_cnt_r;
   logic                  accept_s;
   logic                  sof_hit_s;
   logic [ADDR_WIDTH-1:0] wr_idx_s;

`ifdef LOADER_SOF_SYNC_EN
   logic [7:0]            sof_err_cnt_r;
`else
   logic                  sof_unused_s;
   assign sof_unused_s = i_sof;
`endif

   // Datapath and handshake decode; BRAM write happens in the accept cycle.
   always_comb begin
      o_ready   = 1'b0;
      accept_s  = 1'b0;
      sof_hit_s = 1'b0;
      wr_idx_s  = cnt_r;
      b0_ce0    = 1'b0;
      b0_we0    = 1'b0;
      b0_addr0  = ZERO_ADDR;
      b0_d0     = {DATA_WIDTH{1'b0}};
      o_en      = 1'b0;
      o_num_cnt = ZERO_ADDR;
      o_busy    = 1'b0;

      // Abort masks acceptance so the cancelled cycle never writes BRAM0.
      if ((state_r == ST_LOAD) && !i_abort) begin
         o_ready = 1'b1;
      end else begin
         o_ready = 1'b0;
      end
      accept_s = o_ready && i_valid;

`ifdef LOADER_SOF_SYNC_EN
      sof_hit_s = accept_s && i_sof;
`else
      sof_hit_s = 1'b0;
`endif

      // A SOF-flagged pixel always restarts the frame at address 0.
      if (sof_hit_s) begin
         wr_idx_s = ZERO_ADDR;
      end else begin
         wr_idx_s = cnt_r;
      end

      if (accept_s) begin
         b0_ce0   = 1'b1;
         b0_we0   = 1'b1;
         b0_addr0 = wr_idx_s;
         b0_d0    = i_data;
      end else begin
         b0_ce0   = 1'b0;
         b0_we0   = 1'b0;
         b0_addr0 = ZERO_ADDR;
         b0_d0    = {DATA_WIDTH{1'b0}};
      end

      if ((state_r == ST_START) && !i_abort) begin
         o_en = 1'b1;
      end else begin
         o_en = 1'b0;
      end

      if (state_r != ST_IDLE) begin
         o_busy    = 1'b1;
         o_num_cnt = FRAME_LEN;
      end else begin
         o_busy    = 1'b0;
         o_num_cnt = ZERO_ADDR;
      end
   end

   // Loader FSM, pixel counter and status counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= ZERO_ADDR;
         run_r       <= 1'b0;
         frame_cnt_r <= 16'd0;
`ifdef LOADER_SOF_SYNC_EN
         sof_err_cnt_r <= 8'd0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               // Start together with abort is swallowed: stay idle.
               if (i_start && !i_abort) begin
                  state_r <= ST_LOAD;
                  run_r   <= i_run;
                  cnt_r   <= ZERO_ADDR;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_LOAD: begin
               if (i_abort) begin
                  state_r <= ST_IDLE;
                  cnt_r   <= ZERO_ADDR;
               end else if (accept_s) begin
`ifdef LOADER_SOF_SYNC_EN
                  if (sof_hit_s && (cnt_r != ZERO_ADDR)) begin
                     sof_err_cnt_r <= sat_inc8(sof_err_cnt_r);
                  end else begin
                     sof_err_cnt_r <= sof_err_cnt_r;
                  end
`endif
                  if (wr_idx_s == LAST_IDX) begin
                     state_r <= ST_START;
                     cnt_r   <= ZERO_ADDR;
                  end else begin
                     cnt_r   <= wr_idx_s + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                  end
               end else begin
                  state_r <= ST_LOAD;
               end
            end
            ST_START: begin
               if (i_abort) begin
                  state_r <= ST_IDLE;
                  cnt_r   <= ZERO_ADDR;
               end else begin
                  state_r     <= ST_WAIT_DONE;
                  frame_cnt_r <= frame_cnt_r + 16'd1;
               end
            end
            ST_WAIT_DONE: begin
               if (i_abort) begin
                  state_r <= ST_IDLE;
                  cnt_r   <= ZERO_ADDR;
               end else if (i_done) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_WAIT_DONE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= ZERO_ADDR;
            end
         endcase
      end
   end

   assign o_run       = run_r;
   assign o_frame_cnt = frame_cnt_r;
`ifdef LOADER_SOF_SYNC_EN
   assign o_sof_err_cnt = sof_err_cnt_r;
`else
   assign o_sof_err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_bram_frame_loader.sv
// tb_bram_frame_loader
// Directed bench for bram_frame_loader (default geometry 5x5, 25 pixels).
// Honors LOADER_SOF_SYNC_EN for the SOF resync expectations.
module tb_bram_frame_loader;

   logic        clk;
   logic        rst_n;
   logic        i_start;
   logic        i_run;
   logic        i_abort;
   logic        i_valid;
   logic        i_sof;
   logic [7:0]  i_data;
   logic        o_ready;
   logic        b0_ce0;
   logic        b0_we0;
   logic [15:0] b0_addr0;
   logic [7:0]  b0_d0;
   logic        o_en;
   logic [15:0] o_num_cnt;
   logic        o_run;
   logic        i_done;
   logic        o_busy;
   logic [15:0] o_frame_cnt;
   logic [7:0]  o_sof_err_cnt;

   int n_cmp = 0;
   int n_err = 0;

   // BRAM model and event counters
   logic [7:0] mem [0:31];
   int wr_cnt    = 0;
   int en_cnt    = 0;
   int exp_addr  = 0;
   int order_err = 0;

   bram_frame_loader dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_run(i_run),
      .i_abort(i_abort), .i_valid(i_valid), .i_sof(i_sof), .i_data(i_data),
      .o_ready(o_ready), .b0_ce0(b0_ce0), .b0_we0(b0_we0),
      .b0_addr0(b0_addr0), .b0_d0(b0_d0), .o_en(o_en),
      .o_num_cnt(o_num_cnt), .o_run(o_run), .i_done(i_done),
      .o_busy(o_busy), .o_frame_cnt(o_frame_cnt),
      .o_sof_err_cnt(o_sof_err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (b0_ce0 && b0_we0) begin
         if (b0_addr0 < 16'd32) mem[b0_addr0[4:0]] <= b0_d0;
         if (int'(b0_addr0) != exp_addr) order_err <= order_err + 1;
         exp_addr <= exp_addr + 1;
         wr_cnt   <= wr_cnt + 1;
      end
      if (o_en) en_cnt <= en_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input logic [7:0] d);
      i_valid = 1'b1;
      i_data  = d;
      step();
      i_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"}, {31'd0, o_ready}, 32'd0);
      chk({tag, "_ce"},    {31'd0, b0_ce0},  32'd0);
      chk({tag, "_we"},    {31'd0, b0_we0},  32'd0);
      chk({tag, "_en"},    {31'd0, o_en},    32'd0);
      chk({tag, "_busy"},  {31'd0, o_busy},  32'd0);
      chk({tag, "_addr"},  {16'd0, b0_addr0}, 32'd0);
      chk({tag, "_d0"},    {24'd0, b0_d0},   32'd0);
      chk({tag, "_num"},   {16'd0, o_num_cnt}, 32'd0);
      chk({tag, "_run"},   {31'd0, o_run},   32'd0);
      chk({tag, "_frm"},   {16'd0, o_frame_cnt}, 32'd0);
      chk({tag, "_sof"},   {24'd0, o_sof_err_cnt}, 32'd0);
   endtask

   task automatic clear_counters();
      wr_cnt    = 0;
      en_cnt    = 0;
      exp_addr  = 0;
      order_err = 0;
   endtask

   task automatic begin_frame(input logic run);
      i_start = 1'b1;
      i_run   = run;
      step();
      i_start = 1'b0;
      i_run   = 1'b0;
   endtask

   initial begin
      int further;
      bit seen;
      rst_n = 1'b0; i_start = 1'b0; i_run = 1'b0; i_abort = 1'b0;
      i_valid = 1'b0; i_sof = 1'b0; i_data = 8'd0; i_done = 1'b0;

      // Reset state
      step(); step();
      check_reset_outputs("rst");
      rst_n = 1'b1;
      step();
      clear_counters();

      // Normal back-to-back load with i_run=1
      begin_frame(1'b1);
      chk("norm_busy",  {31'd0, o_busy}, 32'd1);
      chk("norm_num",   {16'd0, o_num_cnt}, 32'd25);
      chk("norm_run",   {31'd0, o_run}, 32'd1);
      chk("norm_ready", {31'd0, o_ready}, 32'd1);
      for (int n = 0; n < 25; n++) begin
         i_valid = 1'b1;
         i_data  = 8'(n);
         #1;
         chk("norm_addr", {16'd0, b0_addr0}, 32'(n));
         chk("norm_we",   {31'd0, b0_we0}, 32'd1);
         step();
      end
      i_valid = 1'b0;
      chk("norm_en_start", {31'd0, o_en}, 32'd1);
      chk("norm_en_early", 32'(en_cnt), 32'd0);
      step();
      chk("norm_en_after", {31'd0, o_en}, 32'd0);
      chk("norm_en_cnt",   32'(en_cnt), 32'd1);
      chk("norm_frm",      {16'd0, o_frame_cnt}, 32'd1);
      chk("norm_wr_cnt",   32'(wr_cnt), 32'd25);
      chk("norm_order",    32'(order_err), 32'd0);
      for (int n = 0; n < 25; n++) chk("norm_mem", {24'd0, mem[n]}, 32'(n));

      // Hold in WAIT_DONE with valid high
      i_valid = 1'b1;
      i_data  = 8'hAA;
      for (int k = 0; k < 10; k++) begin
         #1;
         chk("hold_ready", {31'd0, o_ready}, 32'd0);
         chk("hold_ce",    {31'd0, b0_ce0}, 32'd0);
         step();
      end
      i_valid = 1'b0;
      chk("hold_wr_cnt", 32'(wr_cnt), 32'd25);
      chk("hold_busy",   {31'd0, o_busy}, 32'd1);
      i_done = 1'b1;
      step();
      i_done = 1'b0;
      chk("hold_idle", {31'd0, o_busy}, 32'd0);
      chk("hold_num",  {16'd0, o_num_cnt}, 32'd0);

      // Gapped load, i_valid alternating, i_run=0
      clear_counters();
      begin_frame(1'b0);
      for (int k = 0; k < 50; k++) begin
         i_valid = (k % 2 == 0);
         i_data  = 8'(100 + k / 2);
         step();
      end
      i_valid = 1'b0;
      chk("gap_en_cnt", 32'(en_cnt), 32'd1);
      chk("gap_wr_cnt", 32'(wr_cnt), 32'd25);
      chk("gap_order",  32'(order_err), 32'd0);
      chk("gap_mem0",   {24'd0, mem[0]}, 32'd100);
      chk("gap_mem24",  {24'd0, mem[24]}, 32'd124);
      chk("gap_run",    {31'd0, o_run}, 32'd0);
      chk("gap_frm",    {16'd0, o_frame_cnt}, 32'd2);
      i_done = 1'b1;
      step();
      i_done = 1'b0;

      // Abort after 12 pixels
      clear_counters();
      begin_frame(1'b1);
      for (int n = 0; n < 12; n++) push(8'(n));
      i_abort = 1'b1;
      i_valid = 1'b1;
      i_data  = 8'hEE;
      #1;
      chk("abort_ce", {31'd0, b0_ce0}, 32'd0);
      step();
      i_abort = 1'b0;
      i_valid = 1'b0;
      chk("abort_idle",   {31'd0, o_busy}, 32'd0);
      chk("abort_frm",    {16'd0, o_frame_cnt}, 32'd2);
      chk("abort_wr_cnt", 32'(wr_cnt), 32'd12);
      chk("abort_en_cnt", 32'(en_cnt), 32'd0);
      clear_counters();
      begin_frame(1'b1);
      i_valid = 1'b1;
      i_data  = 8'd200;
      #1;
      chk("abort_restart_addr", {16'd0, b0_addr0}, 32'd0);
      step();
      for (int n = 1; n < 25; n++) push(8'(200 + n));
      step();
      chk("abort_full_wr",  32'(wr_cnt), 32'd25);
      chk("abort_full_ord", 32'(order_err), 32'd0);
      chk("abort_full_en",  32'(en_cnt), 32'd1);
      chk("abort_full_frm", {16'd0, o_frame_cnt}, 32'd3);
      i_done = 1'b1;
      step();
      i_done = 1'b0;

      // Start together with abort in IDLE stays idle
      i_start = 1'b1;
      i_abort = 1'b1;
      step();
      i_start = 1'b0;
      i_abort = 1'b0;
      chk("start_abort_idle", {31'd0, o_busy}, 32'd0);

      // SOF flagged on the 8th pixel
      clear_counters();
      begin_frame(1'b0);
      for (int n = 0; n < 7; n++) push(8'(50 + n));
      i_valid = 1'b1;
      i_sof   = 1'b1;
      i_data  = 8'h77;
      #1;
`ifdef LOADER_SOF_SYNC_EN
      chk("sof_addr", {16'd0, b0_addr0}, 32'd0);
`else
      chk("sof_addr", {16'd0, b0_addr0}, 32'd7);
`endif
      step();
      i_valid = 1'b0;
      i_sof   = 1'b0;
      further = 0;
      seen    = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         if (o_en) begin
            seen = 1'b1;
         end else begin
            push(8'(k));
            further++;
         end
      end
      chk("sof_en_seen", {31'd0, seen}, 32'd1);
`ifdef LOADER_SOF_SYNC_EN
      chk("sof_further", 32'(further), 32'd24);
      chk("sof_err_cnt", {24'd0, o_sof_err_cnt}, 32'd1);
      chk("sof_mem0",    {24'd0, mem[0]}, 32'h77);
`else
      chk("sof_further", 32'(further), 32'd17);
      chk("sof_err_cnt", {24'd0, o_sof_err_cnt}, 32'd0);
      chk("sof_mem7",    {24'd0, mem[7]}, 32'h77);
`endif
      step();
      i_done = 1'b1;
      step();
      i_done = 1'b0;

      // Reset in the middle of a load
      en_cnt = 0;
      begin_frame(1'b1);
      for (int n = 0; n < 5; n++) push(8'(n));
      i_valid = 1'b1;
      rst_n   = 1'b0;
      step();
      i_valid = 1'b0;
      rst_n   = 1'b1;
      check_reset_outputs("mid_rst");
      for (int k = 0; k < 5; k++) step();
      chk("mid_rst_en", 32'(en_cnt), 32'd0);
      chk("mid_rst_idle", {31'd0, o_busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
